struct96_assembler: RTL and testbench

- Word-stream-to-record transmitter: accepts 32-bit beats over valid/ready and assembles them into packed struct96_t records.
- Drives each record, plus a struct_t status, to a downstream consumer whose input ports are typed struct96_t / struct_t.
- Sits between a 32-bit bus source and struct-typed consumer ports. The struct types are visible in traces, so struct packing must be exact.

---
 rtl/struct96_pkg.sv | 26 ++
 rtl/struct96_assembler_if.sv | 26 ++
 rtl/struct96_out_reg.sv | 53 +++++
 rtl/struct96_assembler.sv | 111 +++++++++++
 tb/tb_struct96_assembler.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/struct96_pkg.sv
// Shared types for the 32-bit-beat to struct96_t record assembler and its consumers.
package struct96_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BEATS_PER_REC = 3;
    localparam int unsigned REC_W         = WORD_W * BEATS_PER_REC;
    localparam int unsigned IDX_W         = 2;

    // Status: m_1 = framing error, m_2 = parity.
    typedef struct packed {
        logic m_1;
        logic m_2;
    } struct_t;

    // Record: m_2 is bit 0, m_1 covers bits [95:1].
    typedef struct packed {
        logic [94:0] m_1;
        logic        m_2;
    } struct96_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DROP    = 1'b1
    } state_e;

endpackage

// File: rtl/struct96_assembler_if.sv
// Beat-input and record-output handshake bundle for struct96_assembler.
interface struct96_assembler_if #(
    parameter int unsigned CNT_W = 8
);

    logic                      in_valid;
    logic                      in_ready;
    logic [31:0]               in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    struct96_pkg::struct96_t   out_rec;
    struct96_pkg::struct_t     out_sts;
    logic [CNT_W-1:0]          rec_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_rec, out_sts, rec_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_rec, out_sts, rec_count
    );

endinterface

// File: rtl/struct96_out_reg.sv
// Output holding register: record/status with valid/ready and the emitted-record counter.
// Optional parity on out_sts.m_2 is enabled by STRUCT96_ASM_PARITY_EN.
module struct96_out_reg
    import struct96_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  struct96_t        load_rec,
    input  logic             load_err,
    input  logic             out_ready,
    output logic             out_valid,
    output struct96_t        out_rec,
    output struct_t          out_sts,
    output logic [CNT_W-1:0] rec_count
);

    logic parity_c;
    logic drain_c;

`ifdef STRUCT96_ASM_PARITY_EN
    // Even parity over the 97-bit record+parity total.
    assign parity_c = ^load_rec;
`else
    assign parity_c = 1'b0;
`endif

    assign drain_c = out_valid && out_ready;

    // A load in the same cycle as a drain replaces the record without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_rec   <= '0;
            out_sts   <= '0;
            rec_count <= '0;
        end else begin
            if (drain_c) begin
                rec_count <= rec_count + CNT_W'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_rec   <= load_rec;
                out_sts   <= '{m_1: load_err, m_2: parity_c};
            end else if (drain_c) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/struct96_assembler.sv
// Assembles 32-bit valid/ready beats into packed struct96_t records with framing status.
// Define STRUCT96_ASM_PARITY_EN to drive even parity on out_sts.m_2.
module struct96_assembler
    import struct96_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter logic        PAD_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    struct96_assembler_if.slave  bus
);

    localparam logic [REC_W-1:0] PAD_FILL = {REC_W{PAD_BIT}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS_PER_REC - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
    logic [REC_W-1:0]  buf_q, buf_d;

    logic              out_free_c;
    logic              completing_c;
    logic              in_ready_c;
    logic              accept_c;
    logic              load_c;
    logic              load_err_c;
    logic [REC_W-1:0]  merged_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            beat_idx_q <= '0;
            buf_q      <= PAD_FILL;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            buf_q      <= buf_d;
        end
    end

    // Next-state, buffer update and handshake decode.
    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        buf_d        = buf_q;
        merged_c     = buf_q;
        load_c       = 1'b0;
        load_err_c   = 1'b0;

        out_free_c   = !bus.out_valid || bus.out_ready;
        completing_c = (state_q == COLLECT) && ((beat_idx_q == LAST_IDX) || bus.in_last);
        // Non-completing beats never wait on the output register.
        in_ready_c   = !rst && (!completing_c || out_free_c);
        accept_c     = bus.in_valid && in_ready_c;

        case (beat_idx_q)
            2'd0:    merged_c[31:0]  = bus.in_data;
            2'd1:    merged_c[63:32] = bus.in_data;
            default: merged_c[95:64] = bus.in_data;
        endcase

        case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    if (completing_c) begin
                        load_c     = 1'b1;
                        // Short (last before idx 2) or long (no last at idx 2) framing.
                        load_err_c = (beat_idx_q != LAST_IDX) || !bus.in_last;
                        beat_idx_d = '0;
                        buf_d      = PAD_FILL;
                        if ((beat_idx_q == LAST_IDX) && !bus.in_last) begin
                            state_d = DROP;
                        end
                    end else begin
                        buf_d      = merged_c;
                        beat_idx_d = beat_idx_q + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (accept_c && bus.in_last) begin
                    state_d    = COLLECT;
                    beat_idx_d = '0;
                end
            end
            default: begin
                state_d    = COLLECT;
                beat_idx_d = '0;
                buf_d      = PAD_FILL;
            end
        endcase
    end

    assign bus.in_ready = in_ready_c;

    struct96_out_reg #(
        .CNT_W (CNT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .load_rec  (merged_c),
        .load_err  (load_err_c),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_rec   (bus.out_rec),
        .out_sts   (bus.out_sts),
        .rec_count (bus.rec_count)
    );

endmodule

// File: tb/tb_struct96_assembler.sv
// Directed self-checking bench for struct96_assembler (counter width 2 to exercise wrap).
module tb_struct96_assembler;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [1:0] exp_cnt;

    struct96_assembler_if #(.CNT_W(2)) bus ();

    struct96_assembler #(
        .CNT_W   (2),
        .PAD_BIT (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sts(input logic err, input logic [95:0] rec);
`ifdef STRUCT96_ASM_PARITY_EN
        return {err, ^rec};
`else
        return {err, 1'b0};
`endif
    endfunction

    // Present one beat and hold it until accepted; returns at accept edge + 1.
    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accept_timeout", 128'(n < 50), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic expect_rec(input string tag, input logic [95:0] rec, input logic err);
        chk({tag, "_valid"}, 128'(bus.out_valid), 128'(1));
        chk({tag, "_rec"},   128'(bus.out_rec),   128'(rec));
        chk({tag, "_sts"},   128'(bus.out_sts),   128'(exp_sts(err, rec)));
    endtask

    // One cycle with out_ready high: record handshakes and the counter advances.
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 2'd1;
        chk({tag, "_count"}, 128'(bus.rec_count), 128'(exp_cnt));
        chk({tag, "_idle"},  128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_cnt       = 2'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(bus.in_ready),  128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_rec",   128'(bus.out_rec),   128'(0));
        chk("rst_out_sts",   128'(bus.out_sts),   128'(0));
        chk("rst_count",     128'(bus.rec_count), 128'(0));
        rst = 1'b0;

        // Exact 3-beat record
        beat(32'h0000_0003, 1'b0);
        beat(32'h2222_2222, 1'b0);
        beat(32'h3333_3333, 1'b1);
        expect_rec("exact", 96'h33333333_22222222_00000003, 1'b0);
        chk("exact_m2",     128'(bus.out_rec.m_2),    128'(1));
        chk("exact_m1_lsb", 128'(bus.out_rec.m_1[0]), 128'(1));
        drain("exact");

        // Short record, single beat
        beat(32'hFFFF_FFFF, 1'b1);
        expect_rec("short", 96'h00000000_00000000_FFFFFFFF, 1'b1);
        drain("short");

        // Long record: first three emitted with error, rest dropped
        beat(32'hA000_0001, 1'b0);
        beat(32'hA000_0002, 1'b0);
        beat(32'hA000_0003, 1'b0);
        expect_rec("long", 96'hA0000003_A0000002_A0000001, 1'b1);
        drain("long");
        beat(32'hA000_0004, 1'b0);
        chk("drop4_valid", 128'(bus.out_valid), 128'(0));
        beat(32'hA000_0005, 1'b1);
        chk("drop5_valid", 128'(bus.out_valid), 128'(0));
        beat(32'hB000_0001, 1'b0);
        beat(32'hB000_0002, 1'b0);
        beat(32'hB000_0003, 1'b1);
        expect_rec("after_drop", 96'hB0000003_B0000002_B0000001, 1'b0);
        drain("after_drop");

        // Backpressure: held record, second record stalls on its last beat
        bus.out_ready = 1'b0;
        beat(32'hC000_0001, 1'b0);
        beat(32'hC000_0002, 1'b0);
        beat(32'hC000_0003, 1'b1);
        expect_rec("bp_first", 96'hC0000003_C0000002_C0000001, 1'b0);
        beat(32'hD000_0001, 1'b0);
        beat(32'hD000_0002, 1'b0);
        chk("bp_hold_rec", 128'(bus.out_rec), 128'(96'hC0000003_C0000002_C0000001));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hD000_0003;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_ready", 128'(bus.in_ready),  128'(0));
            chk("bp_stall_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_stall_rec",   128'(bus.out_rec),   128'(96'hC0000003_C0000002_C0000001));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        exp_cnt = exp_cnt + 2'd1;
        expect_rec("bp_second", 96'hD0000003_D0000002_D0000001, 1'b0);
        chk("bp_swap_count", 128'(bus.rec_count), 128'(exp_cnt));
        drain("bp_second");

        // Reset mid-record discards the partial record
        beat(32'hEEEE_0001, 1'b0);
        beat(32'hEEEE_0002, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", 128'(bus.in_ready), 128'(0));
        rst = 1'b0;
        exp_cnt = 2'd0;
        chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
        chk("mid_rst_count", 128'(bus.rec_count), 128'(0));
        beat(32'h1111_0001, 1'b0);
        beat(32'h1111_0002, 1'b0);
        beat(32'h1111_0003, 1'b1);
        expect_rec("post_rst", 96'h11110003_11110002_11110001, 1'b0);
        drain("post_rst");

        // Two-beat short record pads the top word; then counter wrap
        beat(32'h2222_0001, 1'b0);
        beat(32'h2222_0002, 1'b1);
        expect_rec("short2", 96'h00000000_22220002_22220001, 1'b1);
        drain("short2");
        beat(32'h3333_0001, 1'b1);
        expect_rec("wrap3", 96'h00000000_00000000_33330001, 1'b1);
        drain("wrap3");
        beat(32'h4444_0001, 1'b1);
        expect_rec("wrap0", 96'h00000000_00000000_44440001, 1'b1);
        drain("wrap0");
        beat(32'h5555_0001, 1'b1);
        expect_rec("wrap1", 96'h00000000_00000000_55550001, 1'b1);
        drain("wrap1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
